// File: rtl/sequence_generator.sv
// sequence_generator: builds one round's random digit sequence (0..9) and
// writes it to consecutive sequence-RAM addresses, then flags completion.
// Optional build macro: NO_REPEAT_EN -- rejects a digit equal to the previous one.
module sequence_generator #(
  parameter int          ADDR_W  = 5,
  parameter int          DATA_W  = 4,
  parameter int          MIN_LEN = 4,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              GoGen,
  input  logic [3:0]        Diff,
  output logic              FinGen,
  output logic [ADDR_W:0]   SeqLen,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [DATA_W-1:0] WrData,
  output logic              Busy
);

  localparam int          CAP  = 2**ADDR_W;
  // Galois form of x^16+x^14+x^13+x^11+1 (right-shifting)
  localparam logic [15:0] TAPS = 16'hB400;

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_WRITE, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [15:0]         r_lfsr, w_lfsr_nxt;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     w_len;
  int                  w_len_sum;
  logic [DATA_W-1:0]   w_cand;
  logic                w_accept, w_start, w_last;
`ifdef NO_REPEAT_EN
  logic [DATA_W-1:0]   r_prev;
`endif

  // Candidate digit, round length and control qualifiers
  always_comb begin
    w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? TAPS : 16'h0000);
    w_cand     = r_lfsr[DATA_W-1:0];
    w_len_sum  = MIN_LEN + 32'(Diff);
    w_len      = (w_len_sum > CAP) ? (ADDR_W+1)'(CAP) : (ADDR_W+1)'(w_len_sum);
`ifdef NO_REPEAT_EN
    w_accept   = (w_cand <= DATA_W'(9)) && (w_cand != r_prev);
`else
    w_accept   = (w_cand <= DATA_W'(9));
`endif
    w_start    = GoGen && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_last     = (r_count == SeqLen - (ADDR_W+1)'(1));
  end

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; GoGen is only looked at from IDLE/DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (GoGen) w_state_nxt = S_GEN;
      S_GEN:   if (w_accept) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = w_last ? S_DONE : S_GEN;
      S_DONE:  if (GoGen) w_state_nxt = S_GEN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: free-running LFSR, length latch, address counter, write data
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_lfsr  <= SEED;
      r_count <= '0;
      SeqLen  <= '0;
      WrAddr  <= '0;
      WrData  <= '0;
`ifdef NO_REPEAT_EN
      r_prev  <= '1;
`endif
    end else begin
      r_lfsr <= w_lfsr_nxt;
      if (w_start) begin
        SeqLen  <= w_len;
        r_count <= '0;
`ifdef NO_REPEAT_EN
        r_prev  <= '1;
`endif
      end
      if ((r_state == S_GEN) && w_accept) begin
        WrAddr <= r_count[ADDR_W-1:0];
        WrData <= w_cand;
      end
      if (r_state == S_WRITE) begin
        r_count <= r_count + (ADDR_W+1)'(1);
`ifdef NO_REPEAT_EN
        r_prev  <= WrData;
`endif
      end
    end
  end

  // Status outputs registered from the next state so they line up with it
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      WrEn   <= 1'b0;
      Busy   <= 1'b0;
      FinGen <= 1'b0;
    end else begin
      WrEn   <= (w_state_nxt == S_WRITE);
      Busy   <= (w_state_nxt == S_GEN) || (w_state_nxt == S_WRITE);
      FinGen <= (w_state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: reset values, round lengths,
// digit stream against an LFSR reference, ignored mid-round requests,
// asynchronous reset mid-round, and repeated rounds with varied timing.
module tb_sequence_generator;

  logic       Clk, Rst, GoGen;
  logic [3:0] Diff;
  logic       FinGen, WrEn, Busy;
  logic [5:0] SeqLen;
  logic [4:0] WrAddr;
  logic [3:0] WrData;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef NO_REPEAT_EN
  localparam bit NOREP = 1'b1;
`else
  localparam bit NOREP = 1'b0;
`endif

  sequence_generator dut (
    .Clk(Clk), .Rst(Rst), .GoGen(GoGen), .Diff(Diff),
    .FinGen(FinGen), .SeqLen(SeqLen), .WrEn(WrEn),
    .WrAddr(WrAddr), .WrData(WrData), .Busy(Busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference LFSR: x^16+x^14+x^13+x^11+1, Galois, seeded 16'hACE1
  logic [15:0] m_lfsr;
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One round: request at a falling edge, then track the expected GEN/WRITE
  // sequence cycle by cycle from the reference LFSR.
  task automatic run_round(input logic [3:0] diff, input int len, input bit mid,
                           input bit fin_before);
    int         cnt, cyc, mst;   // mst: 0 GEN, 1 WRITE, 2 DONE
    logic [3:0] cand, ed, prev;
    logic [4:0] ea;
    chk("fin_before_req", {31'd0, FinGen}, {31'd0, fin_before});
    GoGen = 1'b1; Diff = diff;
    @(negedge Clk);
    GoGen = 1'b0;
    mst = 0; cnt = 0; cyc = 0; prev = 4'hF; ed = 4'h0; ea = 5'd0;
    chk("seqlen_latched", {26'd0, SeqLen}, len);
    chk("fin_dropped", {31'd0, FinGen}, 32'd0);
    while (mst != 2 && cyc < 1000) begin
      chk("wren", {31'd0, WrEn}, {31'd0, (mst == 1)});
      chk("busy", {31'd0, Busy}, 32'd1);
      if (mst == 0) begin
        cand = m_lfsr[3:0];
        if (cand <= 4'd9 && !(NOREP && cand == prev)) begin
          mst = 1; ea = cnt[4:0]; ed = cand;
        end
      end else begin
        chk("wraddr", {27'd0, WrAddr}, {27'd0, ea});
        chk("wrdata", {28'd0, WrData}, {28'd0, ed});
        chk("wrdata_le9", {31'd0, (WrData <= 4'd9)}, 32'd1);
        if (NOREP && cnt > 0) chk("no_repeat", {31'd0, (WrData != prev)}, 32'd1);
        prev = ed;
        cnt++;
        mst = (cnt == len) ? 2 : 0;
      end
      GoGen = (mid && cyc == 3);
      Diff  = (mid && cyc == 3) ? 4'd9 : diff;
      @(negedge Clk);
      cyc++;
    end
    chk("round_finished", {31'd0, (mst == 2)}, 32'd1);
    chk("write_count", cnt, len);
    chk("fin_done", {31'd0, FinGen}, 32'd1);
    chk("busy_done", {31'd0, Busy}, 32'd0);
    chk("wren_done", {31'd0, WrEn}, 32'd0);
    chk("seqlen_done", {26'd0, SeqLen}, len);
    @(negedge Clk);
    chk("fin_held", {31'd0, FinGen}, 32'd1);
  endtask

  initial begin
    int nw, cyc;
    Rst = 1'b0; GoGen = 1'b0; Diff = 4'd0;

    // 1: reset
    repeat (2) @(negedge Clk);
    chk("rst_fin",    {31'd0, FinGen}, 32'd0);
    chk("rst_wren",   {31'd0, WrEn},   32'd0);
    chk("rst_busy",   {31'd0, Busy},   32'd0);
    chk("rst_seqlen", {26'd0, SeqLen}, 32'd0);
    chk("rst_wraddr", {27'd0, WrAddr}, 32'd0);
    chk("rst_wrdata", {28'd0, WrData}, 32'd0);
    Rst = 1'b1;
    repeat (2) @(negedge Clk);

    // 2: minimum length
    run_round(4'd0, 4, 1'b0, 1'b0);
    repeat (3) @(negedge Clk);

    // 3: longest length, then an immediate restart from DONE
    run_round(4'd15, 19, 1'b0, 1'b1);
    repeat (2) @(negedge Clk);
    run_round(4'd1, 5, 1'b0, 1'b1);

    // 4: request pulsed mid-round with a different Diff is ignored
    run_round(4'd2, 6, 1'b1, 1'b1);

    // 5: asynchronous reset after the second write
    GoGen = 1'b1; Diff = 4'd3;
    @(negedge Clk);
    GoGen = 1'b0;
    nw = 0; cyc = 0;
    while (nw < 2 && cyc < 200) begin
      if (WrEn === 1'b1) nw++;
      if (nw < 2) begin
        @(negedge Clk);
        cyc++;
      end
    end
    chk("rst_mid_two_writes", nw, 32'd2);
    #2 Rst = 1'b0;
    #1;
    chk("rst_mid_wren",   {31'd0, WrEn},   32'd0);
    chk("rst_mid_busy",   {31'd0, Busy},   32'd0);
    chk("rst_mid_fin",    {31'd0, FinGen}, 32'd0);
    chk("rst_mid_wraddr", {27'd0, WrAddr}, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    run_round(4'd0, 4, 1'b0, 1'b0);

    // 6: many long rounds with varied request timing
    for (int i = 0; i < 20; i++) begin
      repeat ((i * 5) % 7 + 1) @(negedge Clk);
      run_round(4'd15, 19, 1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
